imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 38 +++
 rtl/imem_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared definitions for the instruction-memory loader:
//                FSM state encoding, per-phase byte counts and the
//                little-endian byte-order helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  // Loader phases: wait for start, length header, payload, checksum, finish.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    FIN  = 3'd4
  } state_t;

  // Bytes consumed in each byte-accepting phase.
  localparam int LEN_BYTES  = 2;
  localparam int DATA_BYTES = 4;
  localparam int CHK_BYTES  = 1;

  localparam int BYTE_W = 8;

  // Little-endian ordering: the first byte of the length header is the low
  // byte, and byte k of a data word lands in bits [8k+7:8k].
  localparam int LEN_LO_IDX = 0;

  function automatic int le_lane(input logic [1:0] idx);
    return int'(idx) * BYTE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a byte stream [N lo, N hi, 4*N data bytes, checksum]
//                and writes the little-endian assembled words to instruction
//                memory at consecutive word addresses starting at 0.
//  Ports       : clk, rst (async, active high)
//                start                 - begin a load (honoured only in IDLE)
//                byte_valid/byte_data  - stream source, byte_ready handshake
//                mem_we/mem_addr/mem_wdata - one-cycle memory write
//                busy/done/error       - status; error is sticky until start
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32   // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Counters must represent N == 2^ADDR_WIDTH as well as any 16-bit N.
  localparam int CNT_W = (ADDR_WIDTH + 1 > 17) ? ADDR_WIDTH + 1 : 17;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(64'd1 << ADDR_WIDTH);
  localparam logic [1:0] LAST_LEN  = 2'(LEN_BYTES - 1);
  localparam logic [1:0] LAST_DATA = 2'(DATA_BYTES - 1);
  localparam logic [1:0] LAST_CHK  = 2'(CHK_BYTES - 1);

  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]      word_idx_q, word_idx_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [7:0]            cksum_q, cksum_d;

  logic                  byte_ready_q, byte_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  xfer;
  logic [CNT_W-1:0]      len_word;

  assign xfer = byte_valid & byte_ready_q;

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    n_d         = n_q;
    len_lo_d    = len_lo_q;
    word_d      = word_q;
    cksum_d     = cksum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = error_q;
    len_word    = CNT_W'({byte_data, len_lo_q});

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LEN;
          error_d    = 1'b0;
          byte_idx_d = '0;
          word_idx_d = '0;
          cksum_d    = '0;
        end
      end

      LEN: begin
        if (xfer) begin
          if (byte_idx_q == 2'(LEN_LO_IDX)) begin
            len_lo_d = byte_data;
          end
          if (byte_idx_q == LAST_LEN) begin
            n_d        = len_word;
            byte_idx_d = '0;
            if (len_word > MAX_WORDS) begin
              error_d = 1'b1;
              state_d = FIN;
            end else if (len_word == '0) begin
              state_d = CHK;
            end else begin
              state_d = DATA;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      DATA: begin
        if (xfer) begin
          word_d[le_lane(byte_idx_q) +: BYTE_W] = byte_data;
          cksum_d = cksum_q + byte_data;
          if (byte_idx_q == LAST_DATA) begin
            // Word complete: the registered strobe appears next cycle.
            byte_idx_d  = '0;
            mem_we_d    = 1'b1;
            mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
            mem_wdata_d = word_d;
            word_idx_d  = word_idx_q + CNT_W'(1);
            if (word_idx_d == n_q) begin
              state_d = CHK;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      CHK: begin
        if (xfer) begin
          if (byte_data != cksum_q) begin
            error_d = 1'b1;
          end
          if (byte_idx_q == LAST_CHK) begin
            byte_idx_d = '0;
            state_d    = FIN;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state so that they
    // line up with state_q and never depend combinationally on inputs.
    byte_ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      n_q          <= '0;
      len_lo_q     <= '0;
      word_q       <= '0;
      cksum_q      <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      n_q          <= n_d;
      len_lo_q     <= len_lo_d;
      word_q       <= word_d;
      cksum_q      <= cksum_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

`default_nettype wire
